spio_switch_timeout: RTL and testbench
======================================

// Module: spio_switch_timeout
// PURPOSE
//  Single-input, NUM_PORTS-output multicast packet switch with per-output
//  registered slices and self-timed dropping. A packet is held until every
//  selected output accepts it; outputs still blocked after wait_cycles_i idle
//  cycles, or when drop_i is pulsed, are abandoned and reported on the drop port.
//  Sits between router lookup and link/egress FIFOs; wait counter replaces external drop timers.
// PARAMETERS
//  PKT_BITS    72  packet width, opaque payload
//  NUM_PORTS    4  number of outputs (>=1)
//  WAIT_BITS    8  width of wait_cycles_i and the internal wait counter
//  COUNT_BITS  16  width of the saturating drop counter
// PORTS
//  clk_i               in   1                   clock
//  reset_i             in   1                   reset, asynchronous, active-high
//  in_data_i           in   PKT_BITS            input packet
//  in_sel_i            in   NUM_PORTS           output select mask (multicast)
//  in_vld_i            in   1                   input valid
//  in_rdy_o            out  1                   input ready
//  out_data_o          out  NUM_PORTS*PKT_BITS  output k at [k*PKT_BITS+:PKT_BITS]
//  out_vld_o           out  NUM_PORTS           output valids
//  out_rdy_i           in   NUM_PORTS           output readys
//  wait_cycles_i       in   WAIT_BITS           idle cycles before auto drop; 0 = disabled
//  drop_i              in   1                   force drop of held packet's blocked outputs
//  drop_data_o         out  PKT_BITS            dropped packet
//  drop_outputs_o      out  NUM_PORTS           outputs it was dropped from (0 = no-destination)
//  drop_vld_o          out  1                   one-cycle drop strobe, no backpressure
//  blocked_outputs_o   out  NUM_PORTS           pending & ~free
//  selected_outputs_o  out  NUM_PORTS           pending mask of held packet
//  drop_count_o        out  COUNT_BITS          saturating count of drop events
//  clr_count_i         in   1                   synchronous clear of drop_count_o
// BEHAVIOUR
//  - Reset: held=0, pending=0, wait counter=0, all out_vld_o=0, drop_vld_o=0,
//    drop_count_o=0; out_data_o/drop_data_o 0. Mid-operation reset discards
//    held and in-slice packets silently (no drop report).
//  - free[k] = !out_vld_o[k] | out_rdy_i[k]. send = pending & free (combinational).
//  - in_rdy_o = !held | (pending & ~send)==0 | drop event this cycle. Accept on in_vld_i&in_rdy_o:
//    holding reg <= in_data_i, pending <= in_sel_i, wait counter <= 0.
//  - Each cycle, for k in send: slice k loads held data, out_vld_o[k]<=1; pending[k] cleared.
//    Slice k clears out_vld_o[k] on out_rdy_i[k] with no new load. Latency accept->out_vld_o = 2 edges;
//    throughput 1 pkt/cycle when all selected outputs free.
//  - Held packet with pending==0 at load (empty select): dropped next cycle,
//    drop_outputs_o=0, regardless of out_rdy_i.
//  - Wait counter: +1 each cycle held & send==0 & pending!=0; reset to 0 on load
//    or any send bit; saturates at all-ones.
//  - Drop event when held & pending!=0 & (drop_i | (wait_cycles_i!=0 & counter==wait_cycles_i)):
//    free outputs in send still receive the packet that cycle; drop_outputs_o = pending & ~send;
//    held cleared. If pending & ~send==0 no drop is reported (packet completes normally).
//  - Drop port registered: drop_vld_o high exactly one cycle after the event edge.
//  - drop_count_o +1 per drop_vld_o, saturates at all-ones; clr_count_i wins over increment.
//  - drop_i with nothing held: ignored. wait_cycles_i sampled every cycle (changes take effect immediately).
// STRUCTURE
//  - Shared package/header spio_switch_pkg: default PKT_BITS, port-index helpers,
//    drop-reason encoding constants (DROP_NODEST, DROP_TIMEOUT, DROP_FORCED).
//  - Sub-module spio_switch_out_slice: one-entry valid/ready register, one per output (generate).
//  - Top: holding register, pending mask, wait counter, drop register, drop counter.
// TESTING
//  1 sel=4'b0101, all rdy=1, 100 pkts -> each on outputs 0,2 only, in order, 2-edge latency, in_rdy_o stays 1.
//  2 sel=4'b0000, rdy=4'b0000 -> drop_vld_o each pkt, drop_outputs_o=0, drop_count_o increments.
//  3 wait_cycles_i=5, sel=4'b1111, rdy=4'b1110 -> outputs 1-3 deliver, after 5 idle cycles drop
//    with drop_outputs_o=4'b0001; in_rdy_o low until then.
//  4 wait_cycles_i=0, rdy=0, sel=4'b0001, hold 300 cycles -> no drop; pulse drop_i -> one drop, mask 4'b0001.
//  5 drop_i in same cycle out_rdy_i[2] rises, sel=4'b0110 blocked -> output 2 delivers, drop mask 4'b0010.
//  6 reset_i mid-transfer, then clr_count_i with drop_count_o at all-ones -> all outputs 0, no drop strobe; count 0.

Source files
------------

// File: rtl/spio_switch_pkg.sv
// Shared constants and helpers for the multicast packet switch.
// Drop-reason codes let downstream logging tell the three drop causes apart.
package spio_switch_pkg;

    localparam int DEFAULT_PKT_BITS = 72;

    localparam logic [1:0] DROP_NODEST  = 2'd0;
    localparam logic [1:0] DROP_TIMEOUT = 2'd1;
    localparam logic [1:0] DROP_FORCED  = 2'd2;

    function automatic int port_lsb(input int port, input int bits);
        return port * bits;
    endfunction

    function automatic int port_msb(input int port, input int bits);
        return port * bits + bits - 1;
    endfunction

endpackage

// File: rtl/spio_switch_out_slice.sv
// One-entry valid/ready output register; a new load may replace an entry
// that is leaving in the same cycle.
module spio_switch_out_slice
    import spio_switch_pkg::*;
#(
    parameter int PKT_BITS = DEFAULT_PKT_BITS
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                load_i,
    input  logic [PKT_BITS-1:0] data_i,
    input  logic                rdy_i,
    output logic                vld_o,
    output logic [PKT_BITS-1:0] data_o
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_o  <= 1'b0;
            data_o <= '0;
        end else if (load_i) begin
            vld_o  <= 1'b1;
            data_o <= data_i;
        end else if (rdy_i) begin
            vld_o  <= 1'b0;
        end
    end

endmodule

// File: rtl/spio_switch_timeout.sv
// Single-input multicast switch: holds one packet until every selected output
// takes it, abandoning blocked outputs on timeout or forced drop.
module spio_switch_timeout
    import spio_switch_pkg::*;
#(
    parameter int PKT_BITS   = DEFAULT_PKT_BITS,
    parameter int NUM_PORTS  = 4,
    parameter int WAIT_BITS  = 8,
    parameter int COUNT_BITS = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [PKT_BITS-1:0]           in_data_i,
    input  logic [NUM_PORTS-1:0]          in_sel_i,
    input  logic                          in_vld_i,
    output logic                          in_rdy_o,
    output logic [NUM_PORTS*PKT_BITS-1:0] out_data_o,
    output logic [NUM_PORTS-1:0]          out_vld_o,
    input  logic [NUM_PORTS-1:0]          out_rdy_i,
    input  logic [WAIT_BITS-1:0]          wait_cycles_i,
    input  logic                          drop_i,
    output logic [PKT_BITS-1:0]           drop_data_o,
    output logic [NUM_PORTS-1:0]          drop_outputs_o,
    output logic                          drop_vld_o,
    output logic [NUM_PORTS-1:0]          blocked_outputs_o,
    output logic [NUM_PORTS-1:0]          selected_outputs_o,
    output logic [COUNT_BITS-1:0]         drop_count_o,
    input  logic                          clr_count_i
);

    logic                 held;
    logic [PKT_BITS-1:0]  held_data;
    logic [NUM_PORTS-1:0] pending;
    logic [NUM_PORTS-1:0] free;
    logic [NUM_PORTS-1:0] send;
    logic [NUM_PORTS-1:0] remaining;
    logic [WAIT_BITS-1:0] wait_cnt;
    logic                 timeout;
    logic                 no_dest;
    logic                 drop_evt;
    logic                 drop_fire;
    logic                 accept;

    assign free      = ~out_vld_o | out_rdy_i;
    assign send      = held ? (pending & free) : '0;
    assign remaining = pending & ~send;
    assign no_dest   = held && (pending == '0);
    assign timeout   = (wait_cycles_i != '0) && (wait_cnt == wait_cycles_i);
    // Outputs that are free this cycle still get the packet; only the rest are dropped.
    assign drop_evt  = held && (remaining != '0) && (drop_i || timeout);
    assign drop_fire = no_dest || drop_evt;
    assign in_rdy_o  = !held || (remaining == '0) || drop_evt;
    assign accept    = in_vld_i && in_rdy_o;

    assign blocked_outputs_o  = pending & ~free;
    assign selected_outputs_o = pending;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            held      <= 1'b0;
            held_data <= '0;
            pending   <= '0;
        end else if (accept) begin
            held      <= 1'b1;
            held_data <= in_data_i;
            pending   <= in_sel_i;
        end else if (held && ((remaining == '0) || drop_fire)) begin
            held      <= 1'b0;
            pending   <= '0;
        end else begin
            pending   <= remaining;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wait_cnt <= '0;
        end else if (accept || (send != '0) || !held) begin
            wait_cnt <= '0;
        end else if ((pending != '0) && !(&wait_cnt)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            drop_vld_o     <= 1'b0;
            drop_data_o    <= '0;
            drop_outputs_o <= '0;
        end else begin
            drop_vld_o <= drop_fire;
            if (drop_fire) begin
                drop_data_o    <= held_data;
                drop_outputs_o <= remaining;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            drop_count_o <= '0;
        end else if (clr_count_i) begin
            drop_count_o <= '0;
        end else if (drop_vld_o && !(&drop_count_o)) begin
            drop_count_o <= drop_count_o + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_slice
        spio_switch_out_slice #(
            .PKT_BITS (PKT_BITS)
        ) u_slice (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .load_i  (send[k]),
            .data_i  (held_data),
            .rdy_i   (out_rdy_i[k]),
            .vld_o   (out_vld_o[k]),
            .data_o  (out_data_o[port_msb(k, PKT_BITS):port_lsb(k, PKT_BITS)])
        );
    end

endmodule

// File: tb/tb_spio_switch_timeout.sv
// Scoreboard bench for spio_switch_timeout: per-output and drop queues are filled
// when packets are accepted and drained by a monitor as the DUT emits them.
module tb_spio_switch_timeout;

    localparam int PB = 72;
    localparam int NP = 4;
    localparam int WB = 8;
    localparam int CB = 6;

    typedef struct packed {
        logic [PB-1:0] data;
        logic [NP-1:0] mask;
    } drop_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [PB-1:0]    in_data = '0;
    logic [NP-1:0]    in_sel = '0;
    logic             in_vld = 1'b0;
    logic             in_rdy;
    logic [NP*PB-1:0] out_data;
    logic [NP-1:0]    out_vld;
    logic [NP-1:0]    out_rdy = '0;
    logic [WB-1:0]    wait_cycles = '0;
    logic             drop = 1'b0;
    logic [PB-1:0]    drop_data;
    logic [NP-1:0]    drop_outputs;
    logic             drop_vld;
    logic [NP-1:0]    blocked;
    logic [NP-1:0]    selected;
    logic [CB-1:0]    drop_count;
    logic             clr = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [PB-1:0] exp_q[NP][$];
    drop_t         drop_q[$];

    spio_switch_timeout #(
        .PKT_BITS   (PB),
        .NUM_PORTS  (NP),
        .WAIT_BITS  (WB),
        .COUNT_BITS (CB)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .in_data_i          (in_data),
        .in_sel_i           (in_sel),
        .in_vld_i           (in_vld),
        .in_rdy_o           (in_rdy),
        .out_data_o         (out_data),
        .out_vld_o          (out_vld),
        .out_rdy_i          (out_rdy),
        .wait_cycles_i      (wait_cycles),
        .drop_i             (drop),
        .drop_data_o        (drop_data),
        .drop_outputs_o     (drop_outputs),
        .drop_vld_o         (drop_vld),
        .blocked_outputs_o  (blocked),
        .selected_outputs_o (selected),
        .drop_count_o       (drop_count),
        .clr_count_i        (clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Handshakes are stable at the falling edge and complete on the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NP; k++) begin
                if (out_vld[k] && out_rdy[k]) begin
                    total++;
                    if (exp_q[k].size() == 0) begin
                        bad++;
                        $display("FAIL out%0d_unexpected got=%h required=none", k, out_data[k*PB +: PB]);
                    end else begin
                        logic [PB-1:0] e;
                        e = exp_q[k].pop_front();
                        if (out_data[k*PB +: PB] !== e) begin
                            bad++;
                            $display("FAIL out%0d_data got=%h required=%h", k, out_data[k*PB +: PB], e);
                        end
                    end
                end
            end
            if (drop_vld) begin
                total++;
                if (drop_q.size() == 0) begin
                    bad++;
                    $display("FAIL drop_unexpected got=%h/%b required=none", drop_data, drop_outputs);
                end else begin
                    drop_t d;
                    d = drop_q.pop_front();
                    if ({drop_data, drop_outputs} !== {d.data, d.mask}) begin
                        bad++;
                        $display("FAIL drop_report got=%h/%b required=%h/%b",
                                 drop_data, drop_outputs, d.data, d.mask);
                    end
                end
            end
        end
    end

    function automatic logic [PB-1:0] mk(input int i);
        return {8'(i), $urandom(), $urandom()};
    endfunction

    task automatic idle(input int n);
        in_vld = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves in_vld high so consecutive calls are back to back; returns 1 after the accept edge.
    task automatic send_pkt(input logic [PB-1:0] d, input logic [NP-1:0] sel,
                            input logic [NP-1:0] dlv, input logic [NP-1:0] dmask, input bit dexp);
        int n;
        n = 0;
        in_data = d;
        in_sel  = sel;
        in_vld  = 1'b1;
        @(negedge clk);
        while (!in_rdy && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_rdy) begin
            total++;
            bad++;
            $display("FAIL send_accept_timeout in_rdy=%b required=1", in_rdy);
            in_vld = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        for (int k = 0; k < NP; k++)
            if (dlv[k]) exp_q[k].push_back(d);
        if (dexp) drop_q.push_back('{data: d, mask: dmask});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_vld, drop_vld} !== '0) begin
            bad++;
            $display("FAIL reset_held_valids got=%b required=0", {out_vld, drop_vld});
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (in_rdy !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_rdy got=%b required=1", in_rdy);
        end
        total++;
        if ({out_vld, drop_vld, drop_outputs, selected, blocked} !== '0) begin
            bad++;
            $display("FAIL reset_masks got=%b required=0", {out_vld, drop_vld, drop_outputs, selected, blocked});
        end
        total++;
        if ({out_data, drop_data} !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h required=0", {out_data, drop_data});
        end
        total++;
        if (drop_count !== '0) begin
            bad++;
            $display("FAIL reset_count got=%0d required=0", drop_count);
        end
    endtask

    task automatic test_multicast();
        int c0;
        out_rdy = 4'b1111;
        wait_cycles = '0;
        send_pkt(mk(1000), 4'b0101, 4'b0101, 4'b0000, 1'b0);
        total++;
        if (selected !== 4'b0101) begin
            bad++;
            $display("FAIL mc_selected got=%b required=0101", selected);
        end
        total++;
        if (out_vld !== 4'b0000) begin
            bad++;
            $display("FAIL mc_latency_edge1 got=%b required=0000", out_vld);
        end
        in_vld = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (out_vld !== 4'b0101) begin
            bad++;
            $display("FAIL mc_latency_edge2 got=%b required=0101", out_vld);
        end
        idle(2);
        c0 = cyc;
        for (int i = 0; i < 100; i++) send_pkt(mk(i), 4'b0101, 4'b0101, 4'b0000, 1'b0);
        total++;
        if (cyc - c0 != 100) begin
            bad++;
            $display("FAIL mc_throughput got=%0d cycles required=100", cyc - c0);
        end
        idle(4);
    endtask

    task automatic test_nodest();
        logic [CB-1:0] c0;
        out_rdy = 4'b0000;
        c0 = drop_count;
        for (int i = 0; i < 5; i++) send_pkt(mk(200 + i), 4'b0000, 4'b0000, 4'b0000, 1'b1);
        idle(4);
        total++;
        if (drop_count !== c0 + CB'(5)) begin
            bad++;
            $display("FAIL nodest_count got=%0d required=%0d", drop_count, c0 + CB'(5));
        end
    endtask

    task automatic test_timeout();
        int got;
        int viol;
        got = 0;
        viol = 0;
        out_rdy = 4'b1110;
        wait_cycles = 8'd5;
        send_pkt(mk(300), 4'b0001, 4'b0001, 4'b0000, 1'b0);
        idle(3);
        send_pkt(mk(301), 4'b1111, 4'b1110, 4'b0001, 1'b1);
        in_vld = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                total++;
                if (blocked !== 4'b0001) begin
                    bad++;
                    $display("FAIL to_blocked got=%b required=0001", blocked);
                end
            end
            if (e <= 5 && in_rdy) viol++;
            if (drop_vld && got == 0) got = e;
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL to_in_rdy_low got=%0d high cycles required=0", viol);
        end
        total++;
        if (got != 7) begin
            bad++;
            $display("FAIL to_drop_edge got=%0d required=7", got);
        end
        wait_cycles = '0;
        out_rdy = 4'b1111;
        idle(3);
    endtask

    task automatic test_force_drop();
        int n;
        out_rdy = 4'b0000;
        wait_cycles = '0;
        send_pkt(mk(400), 4'b0001, 4'b0001, 4'b0000, 1'b0);
        idle(2);
        send_pkt(mk(401), 4'b0001, 4'b0000, 4'b0001, 1'b1);
        in_vld = 1'b0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (drop_vld) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL fd_no_auto_drop got=%0d strobes required=0", n);
        end
        total++;
        if (selected !== 4'b0001) begin
            bad++;
            $display("FAIL fd_selected_hold got=%b required=0001", selected);
        end
        drop = 1'b1;
        @(posedge clk);
        #1;
        drop = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (drop_vld) n++;
            @(posedge clk);
            #1;
        end
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL fd_one_strobe got=%0d required=1", n);
        end
        total++;
        if (selected !== 4'b0000) begin
            bad++;
            $display("FAIL fd_selected_after got=%b required=0000", selected);
        end
        out_rdy = 4'b1111;
        idle(3);
    endtask

    task automatic test_drop_race();
        logic [CB-1:0] c0;
        out_rdy = 4'b0000;
        send_pkt(mk(500), 4'b0110, 4'b0110, 4'b0000, 1'b0);
        idle(2);
        send_pkt(mk(501), 4'b0110, 4'b0100, 4'b0010, 1'b1);
        idle(3);
        c0 = drop_count;
        drop = 1'b1;
        out_rdy = 4'b0100;
        @(posedge clk);
        #1;
        drop = 1'b0;
        total++;
        if ({drop_vld, drop_outputs} !== 5'b1_0010) begin
            bad++;
            $display("FAIL race_drop got=%b required=10010", {drop_vld, drop_outputs});
        end
        total++;
        if (out_vld[2] !== 1'b1) begin
            bad++;
            $display("FAIL race_out2_loaded got=%b required=1", out_vld[2]);
        end
        idle(3);
        total++;
        if (drop_count !== c0 + CB'(1)) begin
            bad++;
            $display("FAIL race_count got=%0d required=%0d", drop_count, c0 + CB'(1));
        end
        out_rdy = 4'b1111;
        idle(3);
    endtask

    task automatic test_reset_and_clear();
        int n;
        out_rdy = 4'b0000;
        send_pkt(mk(600), 4'b1111, 4'b1111, 4'b0000, 1'b0);
        send_pkt(mk(601), 4'b0011, 4'b0000, 4'b0000, 1'b0);
        idle(1);
        reset = 1'b1;
        #2;
        for (int k = 0; k < NP; k++) exp_q[k].delete();
        drop_q.delete();
        total++;
        if ({out_vld, selected} !== '0) begin
            bad++;
            $display("FAIL rst_mid_async got=%b required=0", {out_vld, selected});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (drop_vld) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL rst_mid_no_drop got=%0d required=0", n);
        end
        total++;
        if ({out_data, out_vld, drop_count} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%h required=0", {out_data, out_vld, drop_count});
        end
        for (int i = 0; i < 70; i++) send_pkt(mk(700 + i), 4'b0000, 4'b0000, 4'b0000, 1'b1);
        total++;
        if (drop_count !== {CB{1'b1}}) begin
            bad++;
            $display("FAIL cnt_saturate got=%0d required=%0d", drop_count, {CB{1'b1}});
        end
        clr = 1'b1;
        send_pkt(mk(770), 4'b0000, 4'b0000, 4'b0000, 1'b1);
        clr = 1'b0;
        total++;
        if (drop_count !== '0) begin
            bad++;
            $display("FAIL cnt_clear got=%0d required=0", drop_count);
        end
        idle(4);
        total++;
        if (drop_count !== CB'(2)) begin
            bad++;
            $display("FAIL cnt_after_clear got=%0d required=2", drop_count);
        end
    endtask

    initial begin
        test_reset();
        test_multicast();
        test_nodest();
        test_timeout();
        test_force_drop();
        test_drop_race();
        test_reset_and_clear();
        idle(3);
        for (int k = 0; k < NP; k++) begin
            total++;
            if (exp_q[k].size() != 0) begin
                bad++;
                $display("FAIL out%0d_undelivered got=%0d left required=0", k, exp_q[k].size());
            end
        end
        total++;
        if (drop_q.size() != 0) begin
            bad++;
            $display("FAIL drop_unreported got=%0d left required=0", drop_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
